// File: rtl/tcp_seg_sender_pkg.sv
// Shared TCP model definitions: FSM states and header field constants.
// Used by the sending endpoint now and by the receiver endpoint later.
package tcp_pkg;

    localparam int unsigned SEQ_W    = 3;
    localparam int unsigned NIBBLE_W = 4;
    localparam logic        DATA_FLAG = 1'b1;
    localparam logic        ACK_FLAG  = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWaitAck,
        StFail
    } state_e;

    function automatic logic [NIBBLE_W-1:0] data_hdr(input logic [SEQ_W-1:0] seq);
        return {DATA_FLAG, seq};
    endfunction

endpackage

// File: rtl/tcp_seg_sender_if.sv
// Sender bundle: application handshake, forward segment channel, reverse ack channel, status.
// bad_ack_count exists only when TCP_SEG_SENDER_ACKCHK_EN is defined.
interface tcp_seg_sender_if;
    import tcp_pkg::*;

    logic                app_valid;
    logic [NIBBLE_W-1:0] app_data;
    logic                app_ready;
    logic                val;
    logic [NIBBLE_W-1:0] data1;
    logic [NIBBLE_W-1:0] data2;
    logic                ack_val;
    logic [NIBBLE_W-1:0] ack_data1;
    logic [NIBBLE_W-1:0] ack_data2;
    logic                fail;
    logic [7:0]          sent_count;
`ifdef TCP_SEG_SENDER_ACKCHK_EN
    logic [3:0]          bad_ack_count;
`endif

    modport master (
        input  app_valid, app_data, ack_val, ack_data1, ack_data2,
`ifdef TCP_SEG_SENDER_ACKCHK_EN
        output bad_ack_count,
`endif
        output app_ready, val, data1, data2, fail, sent_count
    );

    modport slave (
        output app_valid, app_data, ack_val, ack_data1, ack_data2,
`ifdef TCP_SEG_SENDER_ACKCHK_EN
        input  bad_ack_count,
`endif
        input  app_ready, val, data1, data2, fail, sent_count
    );

endinterface

// File: rtl/tcp_seg_sender_retx_timer.sv
// Per-segment ack timer and retransmission counter for the stop-and-wait sender.
module tcp_retx_timer #(
    parameter int unsigned TIMEOUT  = 8,
    parameter int unsigned MAX_RETX = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    input  logic retx_clr_i,
    input  logic retx_inc_i,
    output logic done_o,
    output logic exhausted_o
);

    logic [3:0] timer_q, timer_d;
    logic [2:0] retx_q, retx_d;

    // Timer only counts while waiting; any other cycle restarts it from zero.
    always_comb begin
        timer_d = run_i ? timer_q + 4'd1 : 4'd0;
        retx_d  = retx_q;
        if (retx_clr_i) begin
            retx_d = '0;
        end else if (retx_inc_i) begin
            retx_d = retx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
            retx_q  <= '0;
        end else begin
            timer_q <= timer_d;
            retx_q  <= retx_d;
        end
    end

    assign done_o      = (timer_q == 4'(TIMEOUT - 1));
    assign exhausted_o = (retx_q == 3'(MAX_RETX));

endmodule

// File: rtl/tcp_seg_sender.sv
// Stop-and-wait TCP segment sender with timeout retransmit and sticky failure.
// Define TCP_SEG_SENDER_ACKCHK_EN to require ack_data2 == ~ack_data1 and count bad acks.
module tcp_seg_sender
    import tcp_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 8,
    parameter int unsigned MAX_RETX = 3
) (
    input  logic               clk,
    input  logic               reset,
    tcp_seg_sender_if.master   bus
);

    state_e              state_q, state_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [NIBBLE_W-1:0] payload_q, payload_d;
    logic [7:0]          sent_q, sent_d;
    logic                val_q, val_d;
    logic [NIBBLE_W-1:0] data1_q, data1_d;
    logic [NIBBLE_W-1:0] data2_q, data2_d;
    logic                fail_q, fail_d;
    logic                run, retx_clr, retx_inc, tmr_done, tmr_exhausted;
    logic                ack_hdr_ok, ack_chk_ok, ack_ok;

    tcp_retx_timer #(
        .TIMEOUT  (TIMEOUT),
        .MAX_RETX (MAX_RETX)
    ) u_retx_timer (
        .clk         (clk),
        .reset       (reset),
        .run_i       (run),
        .retx_clr_i  (retx_clr),
        .retx_inc_i  (retx_inc),
        .done_o      (tmr_done),
        .exhausted_o (tmr_exhausted)
    );

    assign ack_hdr_ok = bus.ack_val && (bus.ack_data1[3] == ACK_FLAG) &&
                        (bus.ack_data1[SEQ_W-1:0] == seq_q);

`ifdef TCP_SEG_SENDER_ACKCHK_EN
    logic [3:0] bad_q, bad_d;

    assign ack_chk_ok = (bus.ack_data2 == ~bus.ack_data1);

    always_comb begin
        bad_d = bad_q;
        if ((state_q == StWaitAck) && bus.ack_val && !ack_chk_ok && (bad_q != 4'hF)) begin
            bad_d = bad_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad_q <= '0;
        end else begin
            bad_q <= bad_d;
        end
    end

    assign bus.bad_ack_count = bad_q;
`else
    logic unused_ack_data2;
    assign unused_ack_data2 = ^bus.ack_data2;
    assign ack_chk_ok       = 1'b1;
`endif

    assign ack_ok = ack_hdr_ok && ack_chk_ok;

    // An ack is tested before the timeout, so an ack on the expiry cycle wins.
    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        payload_d = payload_q;
        sent_d    = sent_q;
        run       = 1'b0;
        retx_clr  = 1'b0;
        retx_inc  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.app_valid) begin
                    payload_d = bus.app_data;
                    retx_clr  = 1'b1;
                    state_d   = StSend;
                end
            end
            StSend: state_d = StWaitAck;
            StWaitAck: begin
                run = 1'b1;
                if (ack_ok) begin
                    seq_d   = seq_q + 1'b1;
                    sent_d  = sent_q + 8'd1;
                    state_d = StIdle;
                end else if (tmr_done) begin
                    if (tmr_exhausted) begin
                        state_d = StFail;
                    end else begin
                        retx_inc = 1'b1;
                        state_d  = StSend;
                    end
                end
            end
            StFail:  state_d = StFail;
            default: state_d = StIdle;
        endcase
        // Outputs are registered against the next state so val lines up with SEND.
        val_d   = (state_d == StSend);
        data1_d = val_d ? data_hdr(seq_d) : '0;
        data2_d = val_d ? payload_d : '0;
        fail_d  = fail_q || (state_d == StFail);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            seq_q     <= '0;
            payload_q <= '0;
            sent_q    <= '0;
            val_q     <= 1'b0;
            data1_q   <= '0;
            data2_q   <= '0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            payload_q <= payload_d;
            sent_q    <= sent_d;
            val_q     <= val_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            fail_q    <= fail_d;
        end
    end

    assign bus.app_ready  = (state_q == StIdle) && !reset;
    assign bus.val        = val_q;
    assign bus.data1      = data1_q;
    assign bus.data2      = data2_q;
    assign bus.fail       = fail_q;
    assign bus.sent_count = sent_q;

endmodule

// File: tb/tb_tcp_seg_sender.sv
// Self-checking bench for tcp_seg_sender: randomized segments against a timing/sequence model.
module tb_tcp_seg_sender;
    import tcp_pkg::*;

    localparam int unsigned T = 8;
    localparam int unsigned R = 3;
    localparam int          P = T + 1;  // cycles between successive transmissions

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tcp_seg_sender_if bus ();

    tcp_seg_sender #(
        .TIMEOUT  (T),
        .MAX_RETX (R)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int exp_seq = 0;
    int exp_sent = 0;

    int         pq_cyc[$];
    logic [3:0] pq_d1[$];
    logic [3:0] pq_d2[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && bus.val) begin
            pq_cyc.push_back(cyc);
            pq_d1.push_back(bus.data1);
            pq_d2.push_back(bus.data2);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog sim_time exceeded limit");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        pq_cyc.delete();
        pq_d1.delete();
        pq_d2.delete();
    endtask

    // Waits (bounded) for app_ready, then offers p for one cycle; returns at the
    // negedge of the SEND cycle.
    task automatic offer(input logic [3:0] p, output int start);
        int w;
        w = 0;
        while (!bus.app_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (!bus.app_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL offer_wait app_ready=%0b expected=1", bus.app_ready);
        end
        bus.app_valid = 1'b1;
        bus.app_data  = p;
        @(negedge clk);
        bus.app_valid = 1'b0;
        bus.app_data  = 4'($urandom);
        start = cyc;
    endtask

    // Drives the matching ack in cycle o after the first transmission. With stale
    // set, junk acks (bit3 set or previous seq) and in-SEND acks appear before it.
    task automatic drive_acks(input int o, input bit stale);
        logic [2:0] s;
        s = exp_seq[2:0];
        for (int m = 0; m <= o; m++) begin
            bus.ack_val = 1'b0;
            if (m == o) begin
                bus.ack_val   = 1'b1;
                bus.ack_data1 = {1'b0, s};
            end else if (stale && (m % P == 0)) begin
                bus.ack_val   = 1'b1;
                bus.ack_data1 = {1'b0, s};
            end else if (stale && $urandom_range(0, 1) == 1) begin
                bus.ack_val   = 1'b1;
                bus.ack_data1 = ($urandom_range(0, 1) == 1) ? {1'b1, s} : {1'b0, s - 3'd1};
            end
            bus.ack_data2 = ~bus.ack_data1;
            @(negedge clk);
        end
        bus.ack_val = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.val, bus.data1, bus.data2, bus.app_ready, bus.fail, bus.sent_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got val=%0b d1=%h d2=%h rdy=%0b fail=%0b sent=%0d exp all 0",
                     bus.val, bus.data1, bus.data2, bus.app_ready, bus.fail, bus.sent_count);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.app_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready got=%0b exp=1", bus.app_ready);
        end
    endtask

    task automatic test_clean();
        int start;
        clear_mon();
        offer(4'hA, start);
        n_cmp++;
        if (bus.val !== 1'b1 || bus.data1 !== 4'b1000 || bus.data2 !== 4'hA) begin
            n_bad++;
            $display("FAIL clean_pulse got val=%0b d1=%b d2=%h exp val=1 d1=1000 d2=a",
                     bus.val, bus.data1, bus.data2);
        end
        drive_acks(1, 1'b0);
        exp_seq++; exp_sent++;
        n_cmp++;
        if (bus.app_ready !== 1'b1 || bus.sent_count !== 8'(exp_sent) || bus.val !== 1'b0 ||
            bus.data1 !== 4'h0 || bus.data2 !== 4'h0) begin
            n_bad++;
            $display("FAIL clean_done got rdy=%0b sent=%0d val=%0b d1=%h d2=%h exp rdy=1 sent=%0d val=0 d1=0 d2=0",
                     bus.app_ready, bus.sent_count, bus.val, bus.data1, bus.data2, exp_sent);
        end
        n_cmp++;
        if (pq_cyc.size() !== 1) begin
            n_bad++;
            $display("FAIL clean_count got=%0d exp=1", pq_cyc.size());
        end
    endtask

    // One segment acked at attempt k, window cycle j (1..T): k+1 transmissions expected.
    task automatic run_checked(input string name, input int k, input int j, input bit stale);
        int         start;
        logic [3:0] p;
        logic [3:0] exp_d1;
        p      = 4'($urandom);
        exp_d1 = {1'b1, exp_seq[2:0]};
        clear_mon();
        offer(p, start);
        drive_acks(k * P + j, stale);
        exp_seq++; exp_sent++;
        n_cmp++;
        if (pq_cyc.size() !== k + 1) begin
            n_bad++;
            $display("FAIL %s_count got=%0d exp=%0d", name, pq_cyc.size(), k + 1);
        end
        for (int i = 0; i < pq_cyc.size(); i++) begin
            n_cmp++;
            if (pq_cyc[i] !== start + i * P || pq_d1[i] !== exp_d1 || pq_d2[i] !== p) begin
                n_bad++;
                $display("FAIL %s_pulse%0d got cyc=%0d d1=%b d2=%h exp cyc=%0d d1=%b d2=%h",
                         name, i, pq_cyc[i], pq_d1[i], pq_d2[i], start + i * P, exp_d1, p);
            end
        end
        n_cmp++;
        if (bus.sent_count !== 8'(exp_sent) || bus.app_ready !== 1'b1 || bus.fail !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_done got sent=%0d rdy=%0b fail=%0b exp sent=%0d rdy=1 fail=0",
                     name, bus.sent_count, bus.app_ready, bus.fail, exp_sent);
        end
    endtask

    task automatic test_timeout();
        run_checked("timeout", 1, 1, 1'b0);
    endtask

    task automatic test_stale();
        run_checked("stale", 1, 2, 1'b1);
    endtask

    task automatic test_collision();
        run_checked("collide", 0, T, 1'b0);
        run_checked("collide_last", R, T, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            run_checked("rand", int'($urandom_range(0, R)), int'($urandom_range(1, T)),
                        1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_fail();
        int start;
        clear_mon();
        offer(4'($urandom), start);
        bus.app_valid = 1'b1;
        repeat ((R + 1) * P + 4) @(negedge clk);
        n_cmp++;
        if (pq_cyc.size() !== R + 1 || bus.fail !== 1'b1 || bus.app_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL fail_state got pulses=%0d fail=%0b rdy=%0b exp pulses=%0d fail=1 rdy=0",
                     pq_cyc.size(), bus.fail, bus.app_ready, R + 1);
        end
        for (int i = 0; i < pq_cyc.size(); i++) begin
            n_cmp++;
            if (pq_cyc[i] !== start + i * P) begin
                n_bad++;
                $display("FAIL fail_spacing%0d got=%0d exp=%0d", i, pq_cyc[i], start + i * P);
            end
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (bus.fail !== 1'b1 || pq_cyc.size() !== R + 1 || bus.sent_count !== 8'(exp_sent)) begin
            n_bad++;
            $display("FAIL fail_sticky got fail=%0b pulses=%0d sent=%0d exp fail=1 pulses=%0d sent=%0d",
                     bus.fail, pq_cyc.size(), bus.sent_count, R + 1, exp_sent);
        end
        bus.app_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.fail !== 1'b0 || bus.app_ready !== 1'b0 || bus.sent_count !== 8'd0) begin
            n_bad++;
            $display("FAIL fail_reset got fail=%0b rdy=%0b sent=%0d exp 0 0 0",
                     bus.fail, bus.app_ready, bus.sent_count);
        end
        reset = 1'b0;
        exp_seq = 0; exp_sent = 0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int start;
        for (int i = 0; i < 9; i++) begin
            clear_mon();
            offer(4'(i), start);
            drive_acks(1, 1'b0);
            exp_seq++; exp_sent++;
            n_cmp++;
            if (pq_cyc.size() !== 1 || pq_d1[0] !== {1'b1, 3'(i % 8)}) begin
                n_bad++;
                $display("FAIL wrap%0d got pulses=%0d d1=%b exp pulses=1 d1=%b",
                         i, pq_cyc.size(), pq_d1[0], {1'b1, 3'(i % 8)});
            end
        end
        n_cmp++;
        if (bus.sent_count !== 8'd9) begin
            n_bad++;
            $display("FAIL wrap_sent got=%0d exp=9", bus.sent_count);
        end
    endtask

    task automatic test_reset_mid();
        int start;
        offer(4'($urandom), start);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.val, bus.data1, bus.data2, bus.app_ready, bus.fail, bus.sent_count} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs got val=%0b d1=%h d2=%h rdy=%0b fail=%0b sent=%0d exp all 0",
                     bus.val, bus.data1, bus.data2, bus.app_ready, bus.fail, bus.sent_count);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_seq = 0; exp_sent = 0;
        @(negedge clk);
        clear_mon();
        offer(4'h5, start);
        n_cmp++;
        if (bus.val !== 1'b1 || bus.data1 !== 4'b1000 || bus.data2 !== 4'h5) begin
            n_bad++;
            $display("FAIL midreset_seq got val=%0b d1=%b d2=%h exp val=1 d1=1000 d2=5",
                     bus.val, bus.data1, bus.data2);
        end
        drive_acks(1, 1'b0);
        exp_seq++; exp_sent++;
        n_cmp++;
        if (bus.sent_count !== 8'(exp_sent)) begin
            n_bad++;
            $display("FAIL midreset_sent got=%0d exp=%0d", bus.sent_count, exp_sent);
        end
    endtask

`ifdef TCP_SEG_SENDER_ACKCHK_EN
    task automatic test_ackchk();
        int start;
        clear_mon();
        offer(4'h3, start);
        @(negedge clk);
        bus.ack_val   = 1'b1;
        bus.ack_data1 = {1'b0, exp_seq[2:0]};
        bus.ack_data2 = 4'h0 ^ {4{exp_seq[2:0] != 3'd0}} & ~bus.ack_data1;
        if (exp_seq[2:0] == 3'd0) bus.ack_data2 = 4'h0;
        else bus.ack_data2 = bus.ack_data1;
        @(negedge clk);
        n_cmp++;
        if (bus.bad_ack_count !== 4'd1 || bus.app_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ackchk_reject got bad=%0d rdy=%0b exp bad=1 rdy=0",
                     bus.bad_ack_count, bus.app_ready);
        end
        bus.ack_data2 = ~bus.ack_data1;
        @(negedge clk);
        bus.ack_val = 1'b0;
        exp_seq++; exp_sent++;
        n_cmp++;
        if (bus.sent_count !== 8'(exp_sent) || bus.app_ready !== 1'b1 || bus.bad_ack_count !== 4'd1) begin
            n_bad++;
            $display("FAIL ackchk_accept got sent=%0d rdy=%0b bad=%0d exp sent=%0d rdy=1 bad=1",
                     bus.sent_count, bus.app_ready, bus.bad_ack_count, exp_sent);
        end
    endtask
`endif

    initial begin
        bus.app_valid = 1'b0;
        bus.app_data  = 4'h0;
        bus.ack_val   = 1'b0;
        bus.ack_data1 = 4'h0;
        bus.ack_data2 = 4'h0;
        test_reset();
        test_clean();
        test_timeout();
        test_stale();
        test_collision();
        test_random();
        test_fail();
        test_wrap();
        test_reset_mid();
`ifdef TCP_SEG_SENDER_ACKCHK_EN
        test_ackchk();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tcp_seg_sender.md
Name: tcp_seg_sender

Overview:
- Sending endpoint of the TCP model: the transmitter that feeds the network channel's val/data1/data2 inputs.
- Takes one 4-bit application nibble at a time and wraps it as a segment with a 3-bit sequence number.
- Stop-and-wait: holds each segment until a matching ack returns over the reverse network channel; retransmits on timeout; declares failure after too many retries.

Parameters:
TIMEOUT, 8, cycles spent in WAIT_ACK before retransmit (legal 2..15)
MAX_RETX, 3, retransmissions allowed per segment before FAIL (legal 1..7)

Ports:
clk  input  1  sole clock, all state on posedge
reset  input  1  asynchronous, active-high; all state to reset values
app_valid  input  1  application offers a nibble
app_data  input  4  application payload
app_ready  output  1  sender can accept a nibble this cycle
val  output  1  segment valid to network, one-cycle pulse
data1  output  4  header: bit3=1 (data flag), bits2:0=seq
data2  output  4  payload nibble
ack_val  input  1  ack present from reverse network channel
ack_data1  input  4  ack header: bit3=0, bits2:0=acked seq
ack_data2  input  4  ack check field (see Optional Feature)
fail  output  1  sticky: MAX_RETX exceeded
sent_count  output  8  segments acknowledged, wraps 255->0

Behaviour:
- Reset values: state=IDLE, seq=0, timer=0, retx=0, payload reg=0, val=0, data1=0, data2=0, app_ready=0 during reset then 1 in IDLE, fail=0, sent_count=0.
- val/data1/data2 are registered; data1/data2 are driven 0 whenever val=0.
- States:
  - IDLE: app_ready=1. On app_valid: latch app_data, retx=0, go SEND. app_ready=0 in every other state.
  - SEND: for one cycle, val=1, data1={1,seq}, data2=payload; timer=0; next state WAIT_ACK.
  - WAIT_ACK: timer increments each cycle.
    - Valid ack (ack_val=1, ack_data1[3]=0, ack_data1[2:0]=seq): seq=seq+1 mod 8, sent_count+1, go IDLE.
    - Else, when timer==TIMEOUT-1: if retx==MAX_RETX go FAIL, else retx+1 and go SEND (same seq, same payload).
  - FAIL: fail=1, val=0; stays until reset.
- Latency: app handshake at cycle N -> val=1 at N+1 -> earliest next app_ready at N+3 (ack in the cycle after val).
- Boundary conditions:
  - Ack and timeout expiry in the same cycle: the ack wins; no retransmit.
  - Stale or duplicate acks (wrong seq, or bit3=1): ignored; the timer keeps running.
  - ack_val outside WAIT_ACK: ignored.
  - app_valid while app_ready=0: ignored; the application must hold it.
  - seq wraps 7->0.
  - Reset mid-segment: immediate abort to IDLE; the segment is lost and seq restarts at 0.
- Total transmissions per segment = 1 + MAX_RETX.

Optional Feature:
- Macro TCP_SEG_SENDER_ACKCHK_EN.
- Defined: an ack is valid only if, in addition to the above, ack_data2 == ~ack_data1. Acks failing the check are counted in an extra output, bad_ack_count (4 bits, saturating at 15, reset 0).
- Undefined: ack_data2 is ignored; the bad_ack_count port does not exist.

Decomposition:
- Shared package tcp_pkg:
  - state enum {IDLE, SEND, WAIT_ACK, FAIL}
  - header constants DATA_FLAG=1'b1, ACK_FLAG=1'b0, SEQ_W=3, NIBBLE_W=4
  - Also used by the future receiver endpoint.
- One natural sub-module: tcp_retx_timer, holding the timer and retx counters, with a done/exhausted flag.

Test Plan:
- Clean transfer: app_data=4'hA with ack {0,000} 1 cycle after val -> val pulse with data1=4'b1000, data2=4'hA; sent_count=1; seq=1; app_ready=1 again.
- Timeout retransmit: no ack, TIMEOUT=8 -> second val at +9 cycles with identical data1/data2; an ack then accepted -> sent_count=1.
- Failure: no acks, MAX_RETX=3 -> exactly 4 val pulses, then fail=1 sticky, app_ready=0 until reset.
- Stale ack: in WAIT_ACK with seq=2, ack_data1=4'b0001 -> ignored, retransmit at timeout; later ack 4'b0010 -> accepted.
- Wrap and collision: 9 back-to-back segments -> seq sequence 0..7,0. An ack on the exact timeout cycle -> no retransmit.
- Macro on: ack_data1=4'b0000 with ack_data2=4'h0 -> rejected, bad_ack_count=1. With ack_data2=4'hF -> accepted. Async reset mid-WAIT_ACK -> all outputs at reset values in the same cycle.
